// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
// Module : piano_pkg
// Brief  : Shared constants, types and the scale-1 half-period note table
//          used by the polyphonic voice scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package piano_pkg;

  localparam int NUM_KEYS  = 13;
  localparam int SCALE_MIN = 1;
  localparam int SCALE_MAX = 5;

  typedef logic [3:0] key_idx_t;

  // Kind of event the service stage handles in a given cycle
  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_RELEASE = 2'd1,
    EV_PRESS   = 2'd2
  } ev_kind_t;

  // clk cycles per half tone period at 50 MHz for scale 1, C3 upward,
  // each step divided by 2^(1/12) and truncated
  localparam logic [17:0] NOTE_HP [0:12] = '{
    18'd191113, 18'd180386, 18'd170262, 18'd160706,
    18'd151686, 18'd143172, 18'd135137, 18'd127552,
    18'd120393, 18'd113636, 18'd107258, 18'd101238,
    18'd95556
  };

  // Table lookup that yields 0 for indices past the top key
  function automatic logic [17:0] note_hp(input key_idx_t k);
    if (k <= 4'd12) begin
      return NOTE_HP[k];
    end
    return '0;
  endfunction

  // Right-shift applied to the table: out-of-range scales clamp to 1..5
  function automatic logic [2:0] scale_shift(input logic [2:0] scale);
    if (scale < 3'(SCALE_MIN)) begin
      return 3'd0;
    end
    if (scale > 3'(SCALE_MAX)) begin
      return 3'(SCALE_MAX - 1);
    end
    return scale - 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/voice_scheduler_picker.sv
`default_nettype none
// ============================================================================
// Module : voice_picker
// Brief  : Chooses the voice for a new note: lowest-index idle voice, or
//          when all voices are busy the oldest one (ties to lowest index).
// Rev    : 1.0  initial release
// ============================================================================
module voice_picker #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_VOICES-1:0]            active_i,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] age_i,
  output logic [IDX_W-1:0]                 idx_o,
  output logic                             steal_o
);

  logic             found_free;
  logic [AGE_W-1:0] best_age;

  // Idle voice search first; fall back to the oldest busy voice
  always_comb begin
    idx_o      = '0;
    steal_o    = 1'b0;
    found_free = 1'b0;
    best_age   = age_i[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!active_i[v] && !found_free) begin
        idx_o      = IDX_W'(v);
        found_free = 1'b1;
      end
    end
    if (!found_free) begin
      steal_o = 1'b1;
      idx_o   = '0;
      for (int v = 1; v < NUM_VOICES; v++) begin
        if (age_i[v] > best_age) begin
          best_age = age_i[v];
          idx_o    = IDX_W'(v);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module : voice_scheduler
// Brief  : Polyphony controller. Detects key edges, queues them in pending
//          masks and services one event per cycle, assigning tone voices and
//          driving each voice's key index and half-period count.
// Rev    : 1.0  initial release
// ============================================================================
module voice_scheduler #(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4,
  parameter int HP_W       = 18
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_KEYS-1:0]                  key_state,
  input  logic [2:0]                           scale,
  output logic [NUM_VOICES-1:0]                voice_active,
  output logic [NUM_VOICES-1:0][3:0]           voice_key,
  output logic [NUM_VOICES-1:0][HP_W-1:0]      voice_half_period,
  output logic                                 steal
);

  import piano_pkg::*;

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0]                  key_q;
  logic [NUM_KEYS-1:0]                  press_pend_q, press_pend_d;
  logic [NUM_KEYS-1:0]                  release_pend_q, release_pend_d;
  logic [NUM_VOICES-1:0]                active_q, active_d;
  logic [NUM_VOICES-1:0][3:0]           vkey_q, vkey_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]     age_q, age_d;
  logic [NUM_VOICES-1:0][HP_W-1:0]      hp_q, hp_d;
  logic                                 steal_q, steal_d;

  ev_kind_t                             ev_kind;
  key_idx_t                             ev_key;
  logic [NUM_KEYS-1:0]                  press_clr, release_clr;
  logic [NUM_KEYS-1:0]                  press_det, release_det;
  logic [NUM_KEYS-1:0]                  press_keep, release_keep, cancel;
  logic [IDX_W-1:0]                     pick_idx;
  logic                                 pick_steal;

  voice_picker #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_picker (
    .active_i (active_q),
    .age_i    (age_q),
    .idx_o    (pick_idx),
    .steal_o  (pick_steal)
  );

  // Pick the event to service: any release beats any press, lowest key first
  always_comb begin
    ev_kind = EV_NONE;
    ev_key  = '0;
    if (|release_pend_q) begin
      ev_kind = EV_RELEASE;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
        if (release_pend_q[k]) ev_key = key_idx_t'(k);
      end
    end else if (|press_pend_q) begin
      ev_kind = EV_PRESS;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
        if (press_pend_q[k]) ev_key = key_idx_t'(k);
      end
    end
  end

  // Apply the selected event to the voice table and compute new outputs
  always_comb begin
    active_d    = active_q;
    vkey_d      = vkey_q;
    age_d       = age_q;
    steal_d     = 1'b0;
    press_clr   = '0;
    release_clr = '0;
    case (ev_kind)
      EV_RELEASE: begin
        release_clr[ev_key] = 1'b1;
        // A stolen key matches no voice, so the release simply disappears
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (active_q[v] && (vkey_q[v] == ev_key)) begin
            active_d[v] = 1'b0;
            vkey_d[v]   = '0;
            age_d[v]    = '0;
          end
        end
      end
      EV_PRESS: begin
        press_clr[ev_key] = 1'b1;
        steal_d           = pick_steal;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (IDX_W'(v) == pick_idx) begin
            active_d[v] = 1'b1;
            vkey_d[v]   = ev_key;
            age_d[v]    = '0;
          end else if (active_q[v] && (age_q[v] != {AGE_W{1'b1}})) begin
            age_d[v] = age_q[v] + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    // Half period follows the next voice state and the live scale input,
    // so a scale change reloads every active voice on the next edge
    for (int v = 0; v < NUM_VOICES; v++) begin
      hp_d[v] = active_d[v] ? HP_W'(note_hp(vkey_d[v]) >> scale_shift(scale)) : '0;
    end
  end

  // Edge detection and pending-mask bookkeeping
  always_comb begin
    press_det    = key_state & ~key_q;
    release_det  = ~key_state & key_q;
    press_keep   = press_pend_q & ~press_clr;
    release_keep = release_pend_q & ~release_clr;
    // A key released before its press was serviced vanishes entirely
    cancel         = release_det & press_keep;
    press_pend_d   = (press_keep & ~cancel) | press_det;
    release_pend_d = (release_keep | release_det) & ~cancel;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_q          <= '0;
      press_pend_q   <= '0;
      release_pend_q <= '0;
      active_q       <= '0;
      vkey_q         <= '0;
      age_q          <= '0;
      hp_q           <= '0;
      steal_q        <= 1'b0;
    end else begin
      key_q          <= key_state;
      press_pend_q   <= press_pend_d;
      release_pend_q <= release_pend_d;
      active_q       <= active_d;
      vkey_q         <= vkey_d;
      age_q          <= age_d;
      hp_q           <= hp_d;
      steal_q        <= steal_d;
    end
  end

  assign voice_active      = active_q;
  assign voice_key         = vkey_q;
  assign voice_half_period = hp_q;
  assign steal             = steal_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_voice_scheduler
// Brief  : Directed bench for voice_scheduler with an expectation queue.
// Rev    : 1.0  initial release
// ============================================================================
module tb_voice_scheduler;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [12:0]       key_state;
  logic [2:0]        scale;
  logic [3:0]        voice_active;
  logic [3:0][3:0]   voice_key;
  logic [3:0][17:0]  voice_half_period;
  logic              steal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        tag;
    logic [3:0]   act;
    logic [15:0]  key;
    logic [71:0]  hp;
    logic         stl;
  } exp_t;

  exp_t q[$];

  // Bench-side voice model, set directly by the directed steps
  logic [3:0] m_act;
  int         m_key [4];

  voice_scheduler #(
    .NUM_KEYS   (13),
    .NUM_VOICES (4),
    .AGE_W      (4),
    .HP_W       (18)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .key_state         (key_state),
    .scale             (scale),
    .voice_active      (voice_active),
    .voice_key         (voice_key),
    .voice_half_period (voice_half_period),
    .steal             (steal)
  );

  always #10 clk = ~clk;

  function automatic logic [17:0] exp_hp(int k, int sc);
    int eff;
    int base;
    eff  = (sc == 0) ? 1 : ((sc > 5) ? 5 : sc);
    base = $rtoi(191113.0 * (2.0 ** (-real'(k) / 12.0)));
    return 18'(base >>> (eff - 1));
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_v(int v, int k);
    m_act[v] = 1'b1;
    m_key[v] = k;
  endtask

  task automatic clr_v(int v);
    m_act[v] = 1'b0;
    m_key[v] = 0;
  endtask

  task automatic clr_all();
    for (int v = 0; v < 4; v++) clr_v(v);
  endtask

  // Push the model's expected outputs for the current scale
  task automatic push(string tag, logic stl);
    exp_t e;
    e.tag = tag;
    e.act = m_act;
    e.key = '0;
    e.hp  = '0;
    e.stl = stl;
    for (int v = 0; v < 4; v++) begin
      if (m_act[v]) begin
        e.key[v*4 +: 4]   = 4'(m_key[v]);
        e.hp[v*18 +: 18]  = exp_hp(m_key[v], int'(scale));
      end
    end
    q.push_back(e);
  endtask

  task automatic cmp(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the live outputs
  task automatic check_pop();
    exp_t e;
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL queue: got empty expected entry");
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp({e.tag, ".active"}, 128'(voice_active), 128'(e.act));
      cmp({e.tag, ".key"},    128'(voice_key),    128'(e.key));
      cmp({e.tag, ".hp"},     128'(voice_half_period), 128'(e.hp));
      cmp({e.tag, ".steal"},  128'(steal),        128'(e.stl));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    key_state = '0;
    scale     = 3'd1;
    m_act     = '0;
    for (int v = 0; v < 4; v++) m_key[v] = 0;

    // 1: reset state, then 20 quiet cycles
    tick(3);
    push("reset", 1'b0); check_pop();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      push("idle", 1'b0); check_pop();
    end

    // 2: single press, latency and scale reloads
    key_state = 13'b1;
    tick(1);
    push("lat1", 1'b0); check_pop();
    tick(1);
    set_v(0, 0);
    push("press0", 1'b0); check_pop();
    scale = 3'd3; tick(1); push("scale3", 1'b0); check_pop();
    scale = 3'd7; tick(1); push("scale7", 1'b0); check_pop();
    scale = 3'd0; tick(1); push("scale0", 1'b0); check_pop();
    scale = 3'd1; tick(1); push("scale1", 1'b0); check_pop();
    key_state = '0; tick(2); clr_v(0);
    push("rel0", 1'b0); check_pop();

    // 3: fill all voices, then steal the oldest
    for (int k = 0; k < 4; k++) begin
      key_state[k] = 1'b1;
      tick(2); set_v(k, k);
      push("fill", 1'b0); check_pop();
      tick(3);
    end
    key_state[4] = 1'b1;
    tick(2); set_v(0, 4);
    push("steal_hit", 1'b1); check_pop();
    tick(1); push("steal_end", 1'b0); check_pop();
    key_state[0] = 1'b0;
    tick(2); push("rel_stolen", 1'b0); check_pop();
    key_state = '0;
    tick(6); clr_all();
    push("drain3", 1'b0); check_pop();

    // 4: simultaneous presses serviced lowest key first
    key_state = 13'b0_0000_0010_0100;
    tick(2); set_v(0, 2);
    push("sim_a", 1'b0); check_pop();
    tick(1); set_v(1, 5);
    push("sim_b", 1'b0); check_pop();
    key_state = '0;
    tick(4); clr_all();
    push("drain4", 1'b0); check_pop();

    // 5: release beats press in the same cycle
    key_state = 13'b11;
    tick(3); set_v(0, 0); set_v(1, 1);
    push("two_on", 1'b0); check_pop();
    key_state = 13'b0_0000_1000_0010;
    tick(2); clr_v(0);
    push("rel_first", 1'b0); check_pop();
    tick(1); set_v(0, 7);
    push("press_after", 1'b0); check_pop();

    // Press released before service is dropped without a voice change
    key_state[10] = 1'b1;
    key_state[11] = 1'b1;
    tick(1);
    key_state[11] = 1'b0;
    tick(1); set_v(2, 10);
    push("drop_a", 1'b0); check_pop();
    tick(3);
    push("drop_b", 1'b0); check_pop();
    key_state = '0;
    tick(5); clr_all();
    push("drain5", 1'b0); check_pop();

    // 6: keys held across a reset pulse re-trigger afterwards
    key_state = 13'b0_0010_0000_1000;
    tick(4); set_v(0, 3); set_v(1, 9);
    push("held", 1'b0); check_pop();
    reset_n = 1'b0;
    tick(1); clr_all();
    push("rst_mid", 1'b0); check_pop();
    reset_n = 1'b1;
    tick(2); set_v(0, 3);
    push("post_a", 1'b0); check_pop();
    tick(1); set_v(1, 9);
    push("post_b", 1'b0); check_pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Polyphony controller between key scanning and tone generation. It assigns up to NUM_VOICES tone-generator voices among the 13 keyboard keys and drives each voice's key index and half-period count for the current scale. When all voices are busy, a new press steals the oldest voice. Outputs feed the per-voice square-wave dividers in the tone path.

Parameters:
NUM_KEYS, 13, number of keyboard keys (index 0 = C, 12 = C one octave up)
NUM_VOICES, 4, number of tone-generator voices
AGE_W, 4, width of the per-voice age counter (saturating)
HP_W, 18, width of the half-period output

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  synchronous reset, active-low
key_state  input  NUM_KEYS  debounced key levels, 1 = pressed
scale  input  3  octave select, valid range 1..5
voice_active  output  NUM_VOICES  1 = voice sounding
voice_key  output  NUM_VOICES x 4  key index held by each voice
voice_half_period  output  NUM_VOICES x HP_W  clk cycles per half tone period, 0 when inactive
steal  output  1  one-cycle pulse when an active voice is reassigned

Behaviour:
- One clock (clk). Reset is synchronous and active-low: when reset_n = 0 at a clk edge, all outputs go to 0 and key_q, the pending masks and the ages are cleared.
- Because key_q resets to 0, keys still held when reset is released generate press events.
- Edge detect: key_q <= key_state every cycle.
  - press_pend |= key_state & ~key_q
  - release_pend |= ~key_state & key_q
- A release detected while the same key's press is still pending clears that press_pend bit and the release_pend bit together. The key is dropped with no voice change.
- Service FSM runs one event per cycle.
  - Releases have priority over presses. Within each class, the lowest key index is serviced first.
  - Serviced pending bits are cleared in the same cycle.
- Release of key k: the voice holding k goes inactive; its voice_key and half_period go to 0. If no voice holds k (it was stolen), the event is dropped.
- Press of key k:
  - If any voice is inactive, the lowest-index inactive voice is allocated.
  - Otherwise the voice with the largest age is allocated; ties go to the lowest voice index. steal pulses for one cycle.
  - The allocated voice's age is set to 0. Every other active voice's age increments, saturating at 2^AGE_W-1.
- Latency: for an isolated event, outputs update on the 2nd clk edge after the key_state change (1 cycle sample, 1 cycle service).
- Half-period for an active voice = NOTE_HP[key] >> (scale_eff-1), truncated.
  - scale_eff = 1 when scale is 0; 5 when scale > 5; otherwise scale.
  - Registered output; on a scale change, all active voices reload on the next clk edge.
- An inactive voice always outputs half_period = 0.
- Simultaneous events: pending events queue in the masks. Worst-case drain is 2*NUM_KEYS cycles. No event is lost except under the press-then-release drop rule above.

Decomposition:
- Package piano_pkg holds:
  - NOTE_HP[0:12], the scale-1 half-period table at 50 MHz: key0 = 191113 (C3), each step ÷2^(1/12), key12 = 95556
  - constants NUM_KEYS = 13, SCALE_MIN = 1, SCALE_MAX = 5
  - typedef key_idx_t (logic [3:0])
- Sub-module voice_picker: combinational; takes active mask and ages, returns the voice index and a steal flag.

Test Plan:
1. reset_n = 0 for 3 cycles, all keys 0 -> voice_active = 0, all half_periods = 0, steal = 0 for 20 cycles after release.
2. scale = 1, press key 0 -> 2 cycles later voice_active = 0001, voice_key[0] = 0, half_period[0] = 191113; set scale = 3 -> next cycle 47778; scale = 7 -> 11944.
3. Press keys 0,1,2,3 one per 5 cycles, then key 4 -> voice 0 reassigned to key 4, steal high exactly 1 cycle. Then release key 0 -> no output change.
4. Keys 5 and 2 pressed in the same cycle -> cycle+2: voice 0 = key 2; cycle+3: voice 1 = key 5.
5. With voices 0,1 active (keys 0,1), release key 0 and press key 7 in the same cycle -> release first (voice 0 off), next cycle voice 0 = key 7.
6. Keys 3 and 9 held, voices active; reset_n = 0 for 1 cycle -> outputs 0. After release: voice 0 = key 3 at +2, voice 1 = key 9 at +3.
